ex_stage: RTL and testbench

//  Execute stage: consumes the ID/EX register outputs (operands, immediate, register fields, EX/MEM/WB

---
 rtl/ex_stage_if.sv | 61 ++++++
 rtl/ex_stage.sv | 153 +++++++++++++++
 tb/tb_ex_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX input bundle and EX/MEM output bundle for the execute stage
interface ex_stage_if #(
    parameter int DW = 8,
    parameter int PW = 12
);
    // pipeline control
    logic          stall;
    logic          flush;

    // ID/EX side
    logic          in_valid;
    logic [PW-1:0] in_new_pc;
    logic [DW-1:0] in_data_1;
    logic [DW-1:0] in_data_2;
    logic [7:0]    in_ins70;
    logic [2:0]    in_ins1311;
    logic [2:0]    in_ins75;
    logic          in_EX_is_shift;
    logic          in_EX_alu_src;
    logic          in_EX_update_z_c;
    logic [1:0]    in_EX_scode;
    logic [2:0]    in_EX_acode;
    logic          in_MEM_mem_read_write;
    logic          in_MEM_pc_src;
    logic          in_WB_mem_or_alu;
    logic          in_WB_reg_write_signal;

    // EX/MEM side
    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_store_data;
    logic [PW-1:0] out_branch_target;
    logic [2:0]    out_ins1311;
    logic [2:0]    out_ins75;
    logic          out_zero;
    logic          out_carry;
    logic          out_MEM_mem_read_write;
    logic          out_MEM_pc_src;
    logic          out_WB_mem_or_alu;
    logic          out_WB_reg_write_signal;

    modport slave (
        input  stall, flush,
        input  in_valid, in_new_pc, in_data_1, in_data_2, in_ins70, in_ins1311, in_ins75,
        input  in_EX_is_shift, in_EX_alu_src, in_EX_update_z_c, in_EX_scode, in_EX_acode,
        input  in_MEM_mem_read_write, in_MEM_pc_src, in_WB_mem_or_alu, in_WB_reg_write_signal,
        output out_valid, out_result, out_store_data, out_branch_target, out_ins1311, out_ins75,
        output out_zero, out_carry,
        output out_MEM_mem_read_write, out_MEM_pc_src, out_WB_mem_or_alu, out_WB_reg_write_signal
    );

    modport master (
        output stall, flush,
        output in_valid, in_new_pc, in_data_1, in_data_2, in_ins70, in_ins1311, in_ins75,
        output in_EX_is_shift, in_EX_alu_src, in_EX_update_z_c, in_EX_scode, in_EX_acode,
        output in_MEM_mem_read_write, in_MEM_pc_src, in_WB_mem_or_alu, in_WB_reg_write_signal,
        input  out_valid, out_result, out_store_data, out_branch_target, out_ins1311, out_ins75,
        input  out_zero, out_carry,
        input  out_MEM_mem_read_write, out_MEM_pc_src, out_WB_mem_or_alu, out_WB_reg_write_signal
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, barrel shifter, Z/C flags, branch-target adder, EX/MEM register
module ex_stage #(
    parameter int DW = 8,
    parameter int PW = 12
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] result;
        logic [DW-1:0] store_data;
        logic [PW-1:0] target;
        logic [2:0]    ins1311;
        logic [2:0]    ins75;
        logic          mem_rw;
        logic          pc_src;
        logic          mem_or_alu;
        logic          reg_write;
    } ex_mem_t;

    ex_mem_t       pay_d, pay_q;
    logic          z_d, z_q;
    logic          c_d, c_q;

    logic [DW-1:0] op_a, op_b;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic [2:0]    amt;
    logic [DW:0]   shf_wide;
    logic [2*DW-1:0] rot_wide;
    logic [DW-1:0] shf_res;
    logic          shf_c;
    logic [DW-1:0] result;
    logic          res_c;
    logic [PW-1:0] offset;
    logic          flag_we;

    assign op_a = bus.in_data_1;
    assign op_b = bus.in_EX_alu_src ? DW'(bus.in_ins70) : bus.in_data_2;
    assign amt  = bus.in_ins70[2:0];

    // ALU on DW+1 bits; bit DW is carry for add and borrow for subtract
    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        case (bus.in_EX_acode)
            3'b000:  alu_wide = {1'b0, op_a} + {1'b0, op_b};
            3'b001:  alu_wide = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, c_q};
            3'b010:  alu_wide = {1'b0, op_a} - {1'b0, op_b};
            3'b011:  alu_wide = {1'b0, op_a} - {1'b0, op_b} - {{DW{1'b0}}, c_q};
            3'b100:  alu_res  = op_a & op_b;
            3'b101:  alu_res  = op_a | op_b;
            3'b110:  alu_res  = op_a ^ op_b;
            default: alu_res  = op_b;
        endcase
        if (!bus.in_EX_acode[2]) begin
            alu_res = alu_wide[DW-1:0];
            alu_c   = alu_wide[DW];
        end
    end

    // Barrel shifter; the extra bit of the widened operand catches the last bit shifted out
    always_comb begin
        shf_wide = '0;
        rot_wide = '0;
        shf_res  = '0;
        shf_c    = 1'b0;
        case (bus.in_EX_scode)
            2'b00: begin
                shf_wide = {1'b0, op_a} << amt;
                shf_res  = shf_wide[DW-1:0];
                shf_c    = shf_wide[DW];
            end
            2'b01: begin
                shf_wide = {op_a, 1'b0} >> amt;
                shf_res  = shf_wide[DW:1];
                shf_c    = shf_wide[0];
            end
            2'b10: begin
                rot_wide = {op_a, op_a} << amt;
                shf_res  = rot_wide[2*DW-1:DW];
                shf_c    = c_q;
            end
            default: begin
                rot_wide = {op_a, op_a} >> amt;
                shf_res  = rot_wide[DW-1:0];
                shf_c    = c_q;
            end
        endcase
    end

    // Result select, flag next-state and EX/MEM next-state with flush > stall > load priority
    always_comb begin
        result  = bus.in_EX_is_shift ? shf_res : alu_res;
        res_c   = bus.in_EX_is_shift ? shf_c : alu_c;
        offset  = PW'($signed(bus.in_ins70));
        flag_we = bus.in_valid && bus.in_EX_update_z_c && !bus.stall && !bus.flush;
        z_d     = flag_we ? (result == '0) : z_q;
        c_d     = flag_we ? res_c : c_q;

        pay_d = pay_q;
        if (bus.flush) begin
            pay_d = '0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                pay_d.valid      = 1'b1;
                pay_d.result     = result;
                pay_d.store_data = bus.in_data_2;
                pay_d.target     = bus.in_new_pc + offset;
                pay_d.ins1311    = bus.in_ins1311;
                pay_d.ins75      = bus.in_ins75;
                pay_d.mem_rw     = bus.in_MEM_mem_read_write;
                pay_d.pc_src     = bus.in_MEM_pc_src;
                pay_d.mem_or_alu = bus.in_WB_mem_or_alu;
                pay_d.reg_write  = bus.in_WB_reg_write_signal;
            end else begin
                pay_d = '0;
            end
        end
    end

    // EX/MEM payload and architectural flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pay_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            pay_q <= pay_d;
            z_q   <= z_d;
            c_q   <= c_d;
        end
    end

    assign bus.out_valid               = pay_q.valid;
    assign bus.out_result              = pay_q.result;
    assign bus.out_store_data          = pay_q.store_data;
    assign bus.out_branch_target       = pay_q.target;
    assign bus.out_ins1311             = pay_q.ins1311;
    assign bus.out_ins75               = pay_q.ins75;
    assign bus.out_zero                = z_q;
    assign bus.out_carry               = c_q;
    assign bus.out_MEM_mem_read_write  = pay_q.mem_rw;
    assign bus.out_MEM_pc_src          = pay_q.pc_src;
    assign bus.out_WB_mem_or_alu       = pay_q.mem_or_alu;
    assign bus.out_WB_reg_write_signal = pay_q.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.DW(8), .PW(12)) bus ();
    ex_stage #(.DW(8), .PW(12)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  acode;
        logic [1:0]  scode;
        logic        sh;
        logic        src;
        logic        upd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  imm;
        logic [11:0] pc;
        logic [7:0]  r;
        logic        z;
        logic        c;
        logic [11:0] tgt;
    } vec_t;

    vec_t tbl [16];

    // reference model state
    int m_valid, m_res, m_store, m_tgt, m_i1311, m_i75, m_ctl, m_z, m_c;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic v, input logic [7:0] r, input logic [7:0] st,
                                       input logic [11:0] t, input logic [2:0] i1, input logic [2:0] i2,
                                       input logic [3:0] ctl, input logic z, input logic c);
        return {23'd0, v, r, st, t, i1, i2, ctl, z, c};
    endfunction

    function automatic logic [63:0] dut_sig();
        return pk(bus.out_valid, bus.out_result, bus.out_store_data, bus.out_branch_target,
                  bus.out_ins1311, bus.out_ins75,
                  {bus.out_MEM_mem_read_write, bus.out_MEM_pc_src, bus.out_WB_mem_or_alu,
                   bus.out_WB_reg_write_signal},
                  bus.out_zero, bus.out_carry);
    endfunction

    function automatic logic [63:0] model_sig();
        return pk(m_valid[0], m_res[7:0], m_store[7:0], m_tgt[11:0], m_i1311[2:0], m_i75[2:0],
                  m_ctl[3:0], m_z[0], m_c[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] acode, input logic [1:0] scode, input logic sh,
                         input logic src, input logic upd, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] imm, input logic [11:0] pc);
        bus.in_EX_acode      = acode;
        bus.in_EX_scode      = scode;
        bus.in_EX_is_shift   = sh;
        bus.in_EX_alu_src    = src;
        bus.in_EX_update_z_c = upd;
        bus.in_data_1        = a;
        bus.in_data_2        = b;
        bus.in_ins70         = imm;
        bus.in_new_pc        = pc;
    endtask

    task automatic drive_random();
        drive(3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom));
        bus.in_ins1311             = 3'($urandom);
        bus.in_ins75               = 3'($urandom);
        bus.in_MEM_mem_read_write  = 1'($urandom);
        bus.in_MEM_pc_src          = 1'($urandom);
        bus.in_WB_mem_or_alu       = 1'($urandom);
        bus.in_WB_reg_write_signal = 1'($urandom);
    endtask

    // Arithmetic description of the execute result, from the instruction set definition
    task automatic ref_exec(output int r, output int c);
        int a, b, n, cin, s;
        a   = int'(bus.in_data_1);
        b   = bus.in_EX_alu_src ? int'(bus.in_ins70) : int'(bus.in_data_2);
        n   = int'(bus.in_ins70) % 8;
        cin = m_c;
        r   = 0;
        c   = 0;
        if (bus.in_EX_is_shift) begin
            case (bus.in_EX_scode)
                2'd0: begin r = (a * (1 << n)) % 256; c = (n == 0) ? 0 : (a / (1 << (8 - n))) % 2; end
                2'd1: begin r = a / (1 << n);          c = (n == 0) ? 0 : (a / (1 << (n - 1))) % 2; end
                2'd2: begin r = (a * (1 << n) + a / (1 << (8 - n))) % 256; c = cin; end
                default: begin r = (a / (1 << n) + a * (1 << (8 - n))) % 256; c = cin; end
            endcase
        end else begin
            case (bus.in_EX_acode)
                3'd0: begin s = a + b;        r = s % 256; c = (s > 255) ? 1 : 0; end
                3'd1: begin s = a + b + cin;  r = s % 256; c = (s > 255) ? 1 : 0; end
                3'd2: begin s = a - b;        r = (s + 512) % 256; c = (a < b) ? 1 : 0; end
                3'd3: begin s = a - b - cin;  r = (s + 512) % 256; c = (a < b + cin) ? 1 : 0; end
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = a ^ b;
                default: r = b;
            endcase
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int r, c, off;
        if (rst) begin
            m_valid = 0; m_res = 0; m_store = 0; m_tgt = 0; m_i1311 = 0; m_i75 = 0; m_ctl = 0;
            m_z = 0; m_c = 0;
        end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            m_valid = 0; m_res = 0; m_store = 0; m_tgt = 0; m_i1311 = 0; m_i75 = 0; m_ctl = 0;
        end else if (!bus.stall) begin
            ref_exec(r, c);
            off     = (bus.in_ins70 >= 8'd128) ? int'(bus.in_ins70) - 256 : int'(bus.in_ins70);
            m_valid = 1;
            m_res   = r;
            m_store = int'(bus.in_data_2);
            m_tgt   = (int'(bus.in_new_pc) + off + 4096) % 4096;
            m_i1311 = int'(bus.in_ins1311);
            m_i75   = int'(bus.in_ins75);
            m_ctl   = int'({bus.in_MEM_mem_read_write, bus.in_MEM_pc_src, bus.in_WB_mem_or_alu,
                            bus.in_WB_reg_write_signal});
            if (bus.in_EX_update_z_c) begin
                m_z = (r == 0) ? 1 : 0;
                m_c = c;
            end
        end
    endtask

    initial begin
        //            acode scode sh src upd  a      b      imm    pc       r      z     c     tgt
        tbl[0]  = '{3'd0, 2'd0, 0, 0, 1, 8'hF0, 8'h10, 8'h00, 12'h100, 8'h00, 1'b1, 1'b1, 12'h100};
        tbl[1]  = '{3'd1, 2'd0, 0, 0, 1, 8'h01, 8'h01, 8'h00, 12'h100, 8'h03, 1'b0, 1'b0, 12'h100};
        tbl[2]  = '{3'd2, 2'd0, 0, 1, 1, 8'h03, 8'h00, 8'h05, 12'h100, 8'hFE, 1'b0, 1'b1, 12'h105};
        tbl[3]  = '{3'd3, 2'd0, 0, 0, 1, 8'h10, 8'h0F, 8'h00, 12'h100, 8'h00, 1'b1, 1'b0, 12'h100};
        tbl[4]  = '{3'd0, 2'd1, 1, 0, 1, 8'h81, 8'h00, 8'h01, 12'h100, 8'h40, 1'b0, 1'b1, 12'h101};
        tbl[5]  = '{3'd4, 2'd0, 0, 0, 1, 8'h00, 8'h55, 8'h00, 12'h100, 8'h00, 1'b1, 1'b0, 12'h100};
        tbl[6]  = '{3'd0, 2'd2, 1, 0, 1, 8'h81, 8'h00, 8'h01, 12'h100, 8'h03, 1'b0, 1'b0, 12'h101};
        tbl[7]  = '{3'd0, 2'd0, 1, 0, 1, 8'h5A, 8'h00, 8'h00, 12'h100, 8'h5A, 1'b0, 1'b0, 12'h100};
        tbl[8]  = '{3'd2, 2'd0, 0, 0, 1, 8'h00, 8'h01, 8'h00, 12'h100, 8'hFF, 1'b0, 1'b1, 12'h100};
        tbl[9]  = '{3'd0, 2'd3, 1, 0, 1, 8'h01, 8'h00, 8'h01, 12'h100, 8'h80, 1'b0, 1'b1, 12'h101};
        tbl[10] = '{3'd0, 2'd0, 1, 0, 1, 8'h81, 8'h00, 8'h01, 12'h100, 8'h02, 1'b0, 1'b1, 12'h101};
        tbl[11] = '{3'd6, 2'd0, 0, 0, 1, 8'hFF, 8'hFF, 8'h00, 12'h100, 8'h00, 1'b1, 1'b0, 12'h100};
        tbl[12] = '{3'd5, 2'd0, 0, 0, 0, 8'h00, 8'h0F, 8'h00, 12'h100, 8'h0F, 1'b1, 1'b0, 12'h100};
        tbl[13] = '{3'd7, 2'd0, 0, 1, 0, 8'h00, 8'h00, 8'h03, 12'hFFE, 8'h03, 1'b1, 1'b0, 12'h001};
        tbl[14] = '{3'd7, 2'd0, 0, 1, 0, 8'h00, 8'h00, 8'hFC, 12'h010, 8'hFC, 1'b1, 1'b0, 12'h00C};
        tbl[15] = '{3'd0, 2'd0, 1, 0, 1, 8'h03, 8'h00, 8'h07, 12'h100, 8'h80, 1'b0, 1'b1, 12'h107};

        // reset with random inputs
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        drive_random();
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset", dut_sig(), 64'd0);
            drive_random();
        end

        // table-driven single-cycle vectors
        rst = 1'b0;
        bus.in_ins1311 = 3'd5;
        bus.in_ins75 = 3'd2;
        bus.in_MEM_mem_read_write = 1'b1;
        bus.in_MEM_pc_src = 1'b0;
        bus.in_WB_mem_or_alu = 1'b1;
        bus.in_WB_reg_write_signal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].acode, tbl[i].scode, tbl[i].sh, tbl[i].src, tbl[i].upd,
                  tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].pc);
            step();
            check($sformatf("vec%0d", i), dut_sig(),
                  pk(1'b1, tbl[i].r, tbl[i].b, tbl[i].tgt, 3'd5, 3'd2, 4'b1010, tbl[i].z, tbl[i].c));
        end

        // stall held three cycles: everything frozen
        bus.in_MEM_mem_read_write = 1'b1;
        bus.in_MEM_pc_src = 1'b1;
        bus.in_WB_mem_or_alu = 1'b1;
        bus.in_WB_reg_write_signal = 1'b1;
        drive(3'd0, 2'd0, 0, 0, 1, 8'hF0, 8'h10, 8'h00, 12'h100);
        step();
        check("stall_pre", dut_sig(), pk(1'b1, 8'h00, 8'h10, 12'h100, 3'd5, 3'd2, 4'hF, 1'b1, 1'b1));
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 2'd0, 0, 0, 1, 8'h01, 8'h01, 8'h20, 12'h200);
            bus.in_ins1311 = 3'($urandom);
            step();
            check($sformatf("stall%0d", i), dut_sig(),
                  pk(1'b1, 8'h00, 8'h10, 12'h100, 3'd5, 3'd2, 4'hF, 1'b1, 1'b1));
        end

        // stall and flush on the same edge: bubble, flags kept
        bus.flush = 1'b1;
        step();
        check("stall_flush", dut_sig(), pk(1'b0, 8'h00, 8'h00, 12'h000, 3'd0, 3'd0, 4'h0, 1'b1, 1'b1));

        // invalid entry with update_z_c set must not touch flags
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("invalid_flags", dut_sig(), pk(1'b0, 8'h00, 8'h00, 12'h000, 3'd0, 3'd0, 4'h0, 1'b1, 1'b1));

        // reset beats stall and flush
        bus.in_valid = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        rst = 1'b1;
        step();
        check("reset_prio", dut_sig(), 64'd0);

        // randomized run against the reference model
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        m_valid = 0; m_res = 0; m_store = 0; m_tgt = 0; m_i1311 = 0; m_i75 = 0; m_ctl = 0;
        m_z = 0; m_c = 0;
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            rst          = ($urandom_range(0, 59) == 0);
            bus.stall    = ($urandom_range(0, 4) == 0);
            bus.flush    = ($urandom_range(0, 7) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            model_edge();
            step();
            check($sformatf("rand%0d", i), dut_sig(), model_sig());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
